// File: rtl/vga_sync_out.sv
// ---------------------------------------------------------------------------
// vga_sync_out
//   VGA timing generator and output stage for the object renderers.
//   A clock divider produces one pixel tick every CLK_DIV clk cycles. The
//   col/row scan counters advance on that tick, and every renderer consumes
//   them. The raw hsync/vsync/video-on decodes are delayed by the renderer
//   latency (PIPE_DELAY ticks), so they line up with the composited pixel
//   that comes back. The output stage then registers sync and colour onto
//   the pins, with colour blanked outside the active area.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   col, row     current scan position (10 bit), registered
//   pix_tick     high in the clk cycle at whose end col/row advance
//   frame_start  one-clk pulse in the first cycle of col==0,row==0
//   pixel_in     composited {R,G,B}, valid PIPE_DELAY ticks after its col/row
//   hs, vs       sync outputs, active low
//   r, g, b      4-bit VGA colour
//
// The totals must not exceed 1024, CLK_DIV must be in 1..16, and
// PIPE_DELAY must be in 0..7.
// ---------------------------------------------------------------------------
module vga_sync_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        pix_tick,
  output logic        frame_start,
  input  logic [11:0] pixel_in,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized copies of the timing points, so that every compare against the
  // 10-bit counters is width-matched.
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // One slice of the timing that travels alongside a pixel.
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{hs: 1'b1, vs: 1'b1, von: 1'b0};

  logic [3:0] div;
  logic       line_end;
  logic       frame_end;
  timing_t    t_raw;
  timing_t    t_dly;

  // ---------------------------------------------------------------- divider
  // The tick is decoded from the registered div. With CLK_DIV=1, div stays
  // at 0, so the tick is high in every cycle.
  assign pix_tick = (div == DIV_LAST);

  // NOTE: state updates in always_ff use non-blocking (<=) so every flop
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst)           div <= '0;
    else if (pix_tick) div <= '0;
    else               div <= div + 4'd1;
  end

  // --------------------------------------------------------- scan counters
  assign line_end  = (col == H_LAST);
  assign frame_end = line_end && (row == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_tick) begin
      if (line_end) begin
        col <= '0;
        row <= (row == V_LAST) ? 10'd0 : row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  // ------------------------------------------------------------ raw decode
  assign t_raw.von = (col < H_ACT) && (row < V_ACT);
  assign t_raw.hs  = !((col >= HS_START) && (col < HS_END));
  assign t_raw.vs  = !((row >= VS_START) && (row < VS_END));

  // ------------------------------------------------------- alignment delay
  // The timing is delayed by the renderer latency, so that it is consumed
  // together with the pixel that was computed for the same position.
  if (PIPE_DELAY == 0) begin : g_bypass
    assign t_dly = t_raw;
  end else begin : g_pipe
    timing_t stage [PIPE_DELAY];

    // NOTE: this short delay line is built from flops, not RAM, so resetting
    // it is cheap. The reset also makes sure that the first ticks after
    // reset emit idle sync and blank video rather than stale timing.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DELAY; i++) stage[i] <= TIMING_IDLE;
      end else if (pix_tick) begin
        stage[0] <= t_raw;
        for (int i = 1; i < PIPE_DELAY; i++) stage[i] <= stage[i-1];
      end
    end

    assign t_dly = stage[PIPE_DELAY-1];
  end

  // ----------------------------------------------------------- output stage
  // Outputs move only on pixel ticks. pixel_in is therefore free to change
  // between ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      {r, g, b}   <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      // The counters wrap to 0,0 on this same edge, so the pulse lands in
      // the first cycle of the new frame.
      frame_start <= pix_tick && frame_end;
      if (pix_tick) begin
        hs        <= t_dly.hs;
        vs        <= t_dly.vs;
        {r, g, b} <= t_dly.von ? pixel_in : 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_out.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_out
//   Three instances of vga_sync_out run side by side:
//     a : shrunken 15x8 timing, CLK_DIV=4, PIPE_DELAY=2 (full frames are cheap)
//     b : standard 800x525 timing, CLK_DIV=1, PIPE_DELAY=0
//     c : standard 800x525 timing, CLK_DIV=4, PIPE_DELAY=2
//   A behavioural model computes every output from the number of clk cycles
//   since reset was released. It is compared against each instance on every
//   falling edge. Directed checks with hand-computed literals pin the model.
// ---------------------------------------------------------------------------
module tb_vga_sync_out;

  // Instance a: shrunken timing
  localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;   // H_TOTAL 15
  localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;   // V_TOTAL 8
  localparam int A_D  = 4, A_PD = 2;
  // Instances b and c: standard 640x480 timing
  localparam int S_HA = 640, S_HF = 16, S_HS = 96, S_HB = 48;
  localparam int S_VA = 480, S_VF = 10, S_VS = 2,  S_VB = 33;
  localparam int B_D  = 1, B_PD = 0;
  localparam int C_D  = 4, C_PD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rst_c;
  logic [11:0] pix_a, pix_b, pix_c;
  logic [9:0]  col_a, row_a, col_b, row_b, col_c, row_c;
  logic        tick_a, tick_b, tick_c, fs_a, fs_b, fs_c;
  logic        hs_a, vs_a, hs_b, vs_b, hs_c, vs_c;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  vga_sync_out #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .CLK_DIV(A_D), .PIPE_DELAY(A_PD)
  ) dut_a (
    .clk(clk), .rst(rst_a), .col(col_a), .row(row_a), .pix_tick(tick_a),
    .frame_start(fs_a), .pixel_in(pix_a), .hs(hs_a), .vs(vs_a),
    .r(r_a), .g(g_a), .b(b_a)
  );

  vga_sync_out #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .CLK_DIV(B_D), .PIPE_DELAY(B_PD)
  ) dut_b (
    .clk(clk), .rst(rst_b), .col(col_b), .row(row_b), .pix_tick(tick_b),
    .frame_start(fs_b), .pixel_in(pix_b), .hs(hs_b), .vs(vs_b),
    .r(r_b), .g(g_b), .b(b_b)
  );

  vga_sync_out #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .CLK_DIV(C_D), .PIPE_DELAY(C_PD)
  ) dut_c (
    .clk(clk), .rst(rst_c), .col(col_c), .row(row_c), .pix_tick(tick_c),
    .frame_start(fs_c), .pixel_in(pix_c), .hs(hs_c), .vs(vs_c),
    .r(r_c), .g(g_c), .b(b_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  // k is the clk cycle index after the last reset edge (1 = first cycle).
  // Ticks fall in cycles k = D, 2D, ... Update number j (0-based) takes
  // the timing of the scan position j-PD, and the pixel sampled in that
  // tick cycle (lp).
  // Packing: {col, row, pix_tick, frame_start, hs, vs, rgb} = 36 bits.
  function automatic logic [35:0] model(
      input int k, input int d, input int pd,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb,
      input logic [11:0] lp);
    int ht, vt, f, t, p, q, qc, qr;
    logic [9:0] c, rw;
    logic tk, fs, eh, ev;
    logic [11:0] rgb;
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    f   = ht * vt;
    t   = (k - 1) / d;
    p   = t % f;
    c   = 10'(p % ht);
    rw  = 10'(p / ht);
    tk  = (k % d) == 0;
    fs  = (t > 0) && (t % f == 0) && ((k - 1) % d == 0);
    eh  = 1'b1;
    ev  = 1'b1;
    rgb = 12'h000;
    if (t > 0) begin
      q = t - 1 - pd;
      if (q >= 0) begin
        qc = (q % f) % ht;
        qr = (q % f) / ht;
        eh = !(qc >= ha + hf && qc < ha + hf + hsw);
        ev = !(qr >= va + vf && qr < va + vf + vsw);
        if (qc < ha && qr < va) rgb = lp;
      end
    end
    return {c, rw, tk, fs, eh, ev, rgb};
  endfunction

  int k_a = 0, k_b = 0, k_c = 0;
  logic [11:0] lp_a = '0, lp_b = '0, lp_c = '0;

  always @(posedge clk) begin
    k_a <= rst_a ? 1 : (k_a == 0 ? 0 : k_a + 1);
    k_b <= rst_b ? 1 : (k_b == 0 ? 0 : k_b + 1);
    k_c <= rst_c ? 1 : (k_c == 0 ? 0 : k_c + 1);
  end

  // Single compare process: every instance, every cycle.
  always @(negedge clk) begin
    if (k_a > 0) begin
      check("model_a", {col_a, row_a, tick_a, fs_a, hs_a, vs_a, r_a, g_a, b_a},
            model(k_a, A_D, A_PD, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, lp_a));
      if (k_a % A_D == 0) lp_a = pix_a;
    end
    if (k_b > 0) begin
      check("model_b", {col_b, row_b, tick_b, fs_b, hs_b, vs_b, r_b, g_b, b_b},
            model(k_b, B_D, B_PD, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, lp_b));
      if (k_b % B_D == 0) lp_b = pix_b;
    end
    if (k_c > 0) begin
      check("model_c", {col_c, row_c, tick_c, fs_c, hs_c, vs_c, r_c, g_c, b_c},
            model(k_c, C_D, C_PD, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, lp_c));
      if (k_c % C_D == 0) lp_c = pix_c;
    end
  end

  // Pixel stimulus: a is constant white; b and c change every clk, to show
  // that only tick-cycle values get through.
  initial begin
    pix_a = 12'hFFF;
    pix_b = 12'h000;
    pix_c = 12'h000;
    forever begin
      @(posedge clk);
      #1;
      pix_b = 12'($urandom);
      pix_c = 12'($urandom);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // --------------------------------------------------------------- directed
  initial begin
    int cyc, ticks, cnt, vs_low, white;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    // Cycles 1..5 after release
    @(negedge clk);
    check("c_cyc1_tick", tick_c, 1'b0);
    check("c_cyc1_hs", hs_c, 1'b1);
    check("c_cyc1_vs", vs_c, 1'b1);
    check("c_cyc1_rgb", {r_c, g_c, b_c}, 12'h000);
    check("c_cyc1_fs", fs_c, 1'b0);
    check("b_cyc1_tick", tick_b, 1'b1);
    check("b_cyc1_col", col_b, 10'd0);
    @(negedge clk);
    check("c_cyc2_tick", tick_c, 1'b0);
    check("b_cyc2_col", col_b, 10'd1);
    @(negedge clk);
    check("c_cyc3_tick", tick_c, 1'b0);
    @(negedge clk);
    check("c_cyc4_tick", tick_c, 1'b1);
    check("c_cyc4_col", col_c, 10'd0);
    @(negedge clk);
    check("c_cyc5_tick", tick_c, 1'b0);
    check("c_cyc5_col", col_c, 10'd1);

    // b: no delay, one pixel per clk -> hs low while col is 657..752
    for (int i = 0; i < 2000 && col_b != 10'd656; i++) @(negedge clk);
    check("b_reach_656", col_b == 10'd656, 1'b1);
    check("b_hs_at_656", hs_b, 1'b1);
    @(negedge clk);
    check("b_hs_at_657", hs_b, 1'b0);
    for (int i = 0; i < 200 && col_b != 10'd752; i++) @(negedge clk);
    check("b_hs_at_752", hs_b, 1'b0);
    @(negedge clk);
    check("b_hs_at_753", hs_b, 1'b1);

    // c: two-tick delay -> hs falls on the tick after col reaches 658
    for (int i = 0; i < 5000 && !(col_c == 10'd658 && tick_c); i++) @(negedge clk);
    check("c_reach_658", col_c == 10'd658 && tick_c, 1'b1);
    check("c_hs_before_fall", hs_c, 1'b1);
    @(negedge clk);
    check("c_hs_after_fall", hs_c, 1'b0);
    ticks = 0;
    cnt = 0;
    while (ticks < 800) begin
      @(negedge clk);
      if (tick_c) begin
        ticks++;
        if (!hs_c) cnt++;
      end
    end
    check("c_hs_low_ticks", cnt, 96);

    // a: one full frame between frame_start pulses
    for (int i = 0; i < 1000 && !fs_a; i++) @(negedge clk);
    check("a_reach_fs", fs_a, 1'b1);
    cyc = 0;
    vs_low = 0;
    white = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (tick_a) begin
        if (!vs_a) vs_low++;
        if ({r_a, g_a, b_a} == 12'hFFF) white++;
      end
    end while (!fs_a && cyc < 1000);
    check("a_frame_period", cyc, 480);
    check("a_vs_low_ticks", vs_low, 30);
    check("a_white_ticks", white, 32);
    check("a_fs_row", row_a, 10'd0);

    // a: mid-frame reset inside the visible area
    for (int i = 0; i < 1000 && !(row_a == 10'd2 && col_a == 10'd5); i++) @(negedge clk);
    check("a_reach_r2c5", row_a == 10'd2 && col_a == 10'd5, 1'b1);
    @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("a_rst_pos", {col_a, row_a}, 20'd0);
    check("a_rst_sync", {hs_a, vs_a}, 2'b11);
    check("a_rst_rgb", {r_a, g_a, b_a}, 12'h000);

    // c: mid-line reset, then the start-up sequence repeats
    for (int i = 0; i < 4000 && col_c != 10'd300; i++) @(negedge clk);
    check("c_reach_300", col_c, 10'd300);
    @(posedge clk);
    #1 rst_c = 1'b1;
    @(posedge clk);
    #1 rst_c = 1'b0;
    @(negedge clk);
    check("c_rst_pos", {col_c, row_c}, 20'd0);
    check("c_rst_sync", {hs_c, vs_c}, 2'b11);
    check("c_rst_tick1", tick_c, 1'b0);
    @(negedge clk);
    check("c_rst_tick2", tick_c, 1'b0);
    @(negedge clk);
    check("c_rst_tick3", tick_c, 1'b0);
    @(negedge clk);
    check("c_rst_tick4", tick_c, 1'b1);
    @(negedge clk);
    check("c_rst_col5", col_c, 10'd1);

    repeat (200) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
